// File: rtl/message_readback.sv
// message_readback: streams a winning core's decrypted A RAM message out over valid/ready.
// Optional MESSAGE_READBACK_CHAR_CHECK_EN adds a sticky non-[a-z ] character flag.
module message_readback #(
  parameter int NUM_CORES          = 51,
  parameter int LOG_NUM_CORES      = 8,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter int RAM_WIDTH          = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LOG_NUM_CORES-1:0]      core_sel,
  output logic [LOG_NUM_CORES-1:0]      rd_core,
  output logic [MESSAGE_LOG_LENGTH-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0]          rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RAM_WIDTH-1:0]          out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          char_err
);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} state_t;
  localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
  if (NUM_CORES > 2**LOG_NUM_CORES || MESSAGE_LENGTH > 2**MESSAGE_LOG_LENGTH) begin : g_bad_cfg
    $error("message_readback: parameters do not fit their index widths");
  end
  state_t state, state_n;
  logic [MESSAGE_LOG_LENGTH-1:0] idx;
  logic accept, hs;
  always_comb begin
    state_n = state;
    accept  = start && (state == IDLE || state == DONE);
    hs      = state == SEND && out_ready;
    case (state)
      IDLE, DONE: state_n = start ? READ : state;
      READ:       state_n = CAPTURE;
      CAPTURE:    state_n = SEND;
      SEND:       state_n = !out_ready ? SEND : (idx == LAST ? DONE : READ);
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      rd_core  <= '0;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        rd_core <= core_sel;
        idx     <= '0;
      end
      if (state == CAPTURE) out_data <= rd_data;
      if (hs && idx != LAST) idx <= idx + 1'b1;
    end
  end
  assign rd_addr   = state == IDLE ? '0 : idx;
  assign out_valid = state == SEND;
  assign out_last  = out_valid && idx == LAST;
  assign busy      = state != IDLE && state != DONE;
  assign done      = state == DONE;
`ifdef MESSAGE_READBACK_CHAR_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset || accept) char_err <= 1'b0;
    else if (hs && !(out_data == 8'h20 || (out_data >= 8'h61 && out_data <= 8'h7A))) char_err <= 1'b1;
  end
`else
  assign char_err = 1'b0;
`endif
endmodule

// File: tb/tb_message_readback.sv
// tb_message_readback: directed scoreboard bench for message_readback with a 1-cycle A RAM model.
module tb_message_readback;
  logic       clk = 1'b0;
  logic       reset, start, out_ready;
  logic [7:0] core_sel, rd_core, rd_data, out_data;
  logic [4:0] rd_addr;
  logic       out_valid, out_last, busy, done, char_err;
  logic [7:0] mem [0:255][0:31];
  logic [7:0] q [$];
  int         errors = 0, checks = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
`ifdef MESSAGE_READBACK_CHAR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  message_readback dut (
    .clk(clk), .reset(reset), .start(start), .core_sel(core_sel), .rd_core(rd_core),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .char_err(char_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_core][rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input int c);
    for (int i = 0; i < 32; i++) q.push_back(mem[c][i]);
  endtask

  task automatic wait_byte(input int b);
    int n = 0;
    while (!(out_valid && rd_addr == 5'(b)) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("timeout_byte", 32'(b), 32'hFFFF);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("timeout_done", 0, 1);
  endtask

  // Consumer side: pop on handshake, check last flag and hold-while-stalled.
  always @(negedge clk) begin
    if (!reset) begin
      check("out_last", 32'(out_last), 32'(out_valid && q.size() == 1));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("sb_empty", 1, 0);
        else check("byte", 32'(out_data), 32'(q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else prev_stall = 1'b0;
  end

  initial begin
    string msg = "so quick brown fox jumps over it";
    for (int c = 0; c < 256; c++)
      for (int i = 0; i < 32; i++) mem[c][i] = msg[(i + c) % 32];
    for (int i = 0; i < 32; i++) mem[5][i] = msg[i];
    mem[7][4] = 8'h41;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; core_sel = '0;
    step(); step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_core", 32'(rd_core), 0);
    check("rst_addr", 32'(rd_addr), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_err", 32'(char_err), 0);
    reset = 1'b0;
    step();
    // Basic read from core 5 with a stray start and backpressure along the way.
    core_sel = 8'd5; start = 1'b1; push_msg(5);
    step();
    start = 1'b0; core_sel = 8'd0;
    check("c1_core", 32'(rd_core), 5);
    check("c1_busy", 32'(busy), 1);
    check("c1_valid", 32'(out_valid), 0);
    step();
    check("c2_valid", 32'(out_valid), 0);
    step();
    check("c3_valid", 32'(out_valid), 1);
    check("c3_data", 32'(out_data), 32'h73);
    wait_byte(3);
    core_sel = 8'd9; start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_core", 32'(rd_core), 5);
    wait_byte(7);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'h6B);
      check("bp_addr", 32'(rd_addr), 7);
    end
    out_ready = 1'b1;
    wait_done();
    check("d1_done", 32'(done), 1);
    check("d1_busy", 32'(busy), 0);
    check("d1_left", 32'(q.size()), 0);
    check("d1_err", 32'(char_err), 0);
    // Restart from DONE with core 50.
    core_sel = 8'd50; start = 1'b1; push_msg(50);
    step();
    start = 1'b0;
    check("r_done", 32'(done), 0);
    check("r_core", 32'(rd_core), 50);
    check("r_busy", 32'(busy), 1);
    wait_done();
    check("r_left", 32'(q.size()), 0);
    // Reset in the middle of byte 12, then a clean re-read.
    core_sel = 8'd5; start = 1'b1; push_msg(5);
    step();
    start = 1'b0;
    wait_byte(12);
    reset = 1'b1;
    step();
    check("mr_valid", 32'(out_valid), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check("mr_core", 32'(rd_core), 0);
    check("mr_addr", 32'(rd_addr), 0);
    check("mr_data", 32'(out_data), 0);
    reset = 1'b0;
    q.delete();
    step();
    start = 1'b1; push_msg(5);
    step();
    start = 1'b0;
    check("rr_addr", 32'(rd_addr), 0);
    wait_done();
    check("rr_left", 32'(q.size()), 0);
    // Bad character at byte 4 of core 7.
    core_sel = 8'd7; start = 1'b1; push_msg(7);
    step();
    start = 1'b0;
    wait_byte(4);
    check("ce_before", 32'(char_err), 0);
    step();
    check("ce_after", 32'(char_err), 32'(CHK));
    wait_done();
    check("ce_done", 32'(char_err), 32'(CHK));
    core_sel = 8'd5; start = 1'b1; push_msg(5);
    step();
    start = 1'b0;
    check("ce_clear", 32'(char_err), 0);
    wait_done();
    check("ce_left", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
